// File: rtl/upscale_pkg.sv
// Shared definitions for the bicubic upscaler: controller states, default
// widths and the coefficient-width helper.
package upscale_pkg;

   localparam int BIT_DEPTH = 8;
   localparam int FRAC_BITS = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      DONE = 2'd2
   } state_t;

   // Coefficients carry four guard bits above the pixel range.
   function automatic int coef_width(input int bit_depth);
      return bit_depth + 4;
   endfunction

endpackage

// File: rtl/cubic_horner_step.sv
// One Horner iteration: result = floor(acc * frac / 2^frac_bits) + coef.
// Purely combinational; the evaluator reuses it for all three steps.
module cubic_horner_step
   import upscale_pkg::*;
#(
   parameter  int bit_depth = BIT_DEPTH,
   parameter  int frac_bits = FRAC_BITS,
   localparam int CW        = coef_width(bit_depth),
   localparam int AW        = bit_depth + 6,
   localparam int PW        = bit_depth + 7 + frac_bits
) (
   input  logic signed [AW-1:0]        acc,
   input  logic        [frac_bits-1:0] frac,
   input  logic signed [CW-1:0]        coef,
   output logic signed [AW-1:0]        result
);

   logic signed [PW-1:0] acc_ext;
   logic signed [PW-1:0] frac_ext;
   logic signed [PW-1:0] product;
   logic signed [AW-1:0] coef_ext;
   logic                 unused_product_bits;

   // frac is an unsigned position, so it is zero-extended before the signed multiply.
   assign acc_ext  = {{(PW-AW){acc[AW-1]}}, acc};
   assign frac_ext = {{(PW-frac_bits){1'b0}}, frac};
   assign product  = acc_ext * frac_ext;
   assign coef_ext = {{(AW-CW){coef[CW-1]}}, coef};

   // Selecting bits above frac_bits of a two's-complement product is an
   // arithmetic shift with floor rounding; the scaled value never exceeds |acc|,
   // so the top product bit carries no information.
   assign result = product[frac_bits +: AW] + coef_ext;

   assign unused_product_bits = product[PW-1] ^ (^product[frac_bits-1:0]);

endmodule

// File: rtl/cubic_evaluator.sv
// Sequential Horner evaluator: p(x) = t0 + t1*x + t2*x^2 + t3*x^3 over three
// steps, clamped to the pixel range, with valid/ready on both sides.
module cubic_evaluator
   import upscale_pkg::*;
#(
   parameter  int bit_depth = BIT_DEPTH,
   parameter  int frac_bits = FRAC_BITS,
   localparam int CW        = coef_width(bit_depth),
   localparam int AW        = bit_depth + 6
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [CW-1:0]        t0,
   input  logic signed [CW-1:0]        t1,
   input  logic signed [CW-1:0]        t2,
   input  logic signed [CW-1:0]        t3,
   input  logic        [frac_bits-1:0] frac,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic        [bit_depth-1:0] out_pixel
);

   localparam logic [1:0] LAST_STEP = 2'd2;

   state_t                      state_reg;
   state_t                      state_next;
   logic                        accept;
   logic [1:0]                  count_reg;
   logic signed [AW-1:0]        acc_reg;
   logic signed [AW-1:0]        step_result;
   logic signed [CW-1:0]        coef_in  [3];
   logic signed [CW-1:0]        coef_reg [3];
   logic signed [CW-1:0]        step_coef;
   logic        [frac_bits-1:0] frac_reg;
   logic        [bit_depth-1:0] out_pixel_reg;
   logic        [bit_depth-1:0] clamped;

   assign coef_in[0] = t0;
   assign coef_in[1] = t1;
   assign coef_in[2] = t2;

   // Operand capture is datapath only; it needs no reset because acc and the
   // FSM decide whether anything derived from it is ever used.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < 3; i++) begin
            coef_reg[i] <= coef_in[i];
         end
         frac_reg <= frac;
      end
   end

   always_comb begin
      case (count_reg)
         2'd0:    step_coef = coef_reg[2];
         2'd1:    step_coef = coef_reg[1];
         default: step_coef = coef_reg[0];
      endcase
   end

   cubic_horner_step #(
      .bit_depth (bit_depth),
      .frac_bits (frac_bits)
   ) u_step (
      .acc    (acc_reg),
      .frac   (frac_reg),
      .coef   (step_coef),
      .result (step_result)
   );

   // Negative saturates to 0; any set bit above the pixel field saturates to max.
   always_comb begin
      if (step_result[AW-1]) begin
         clamped = '0;
      end else if (|step_result[AW-2:bit_depth]) begin
         clamped = '1;
      end else begin
         clamped = step_result[bit_depth-1:0];
      end
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               accept     = 1'b1;
               state_next = STEP;
            end
         end
         STEP: begin
            if (count_reg == LAST_STEP) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         acc_reg       <= '0;
         count_reg     <= '0;
         out_pixel_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            acc_reg   <= {{(AW-CW){t3[CW-1]}}, t3};
            count_reg <= '0;
         end else if (state_reg == STEP) begin
            acc_reg   <= step_result;
            count_reg <= count_reg + 2'd1;
            if (count_reg == LAST_STEP) begin
               out_pixel_reg <= clamped;
            end
         end
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign out_pixel = out_pixel_reg;

endmodule

// File: tb/tb_cubic_evaluator.sv
// Directed-vector and randomised bench for cubic_evaluator with a floor-shift
// Horner reference model.
module tb_cubic_evaluator;

   localparam int BD = 8;
   localparam int FB = 8;
   localparam int CW = BD + 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [CW-1:0] t0_s, t1_s, t2_s, t3_s;
   logic        [FB-1:0] frac_s;
   logic                 out_valid;
   logic                 out_ready;
   logic        [BD-1:0] out_pixel;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int t0; int t1; int t2; int t3; int frac; int exp;
   } vec_t;

   vec_t vecs [9];

   cubic_evaluator #(.bit_depth(BD), .frac_bits(FB)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .t0        (t0_s),
      .t1        (t1_s),
      .t2        (t2_s),
      .t3        (t3_s),
      .frac      (frac_s),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pixel (out_pixel)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int ref_pixel(input int t0, input int t1, input int t2,
                                    input int t3, input int frac);
      longint acc;
      acc = t3;
      acc = ((acc * frac) >>> FB) + t2;
      acc = ((acc * frac) >>> FB) + t1;
      acc = ((acc * frac) >>> FB) + t0;
      if (acc < 0) return 0;
      if (acc > 255) return 255;
      return int'(acc);
   endfunction

   task automatic drive_set(input int t0, input int t1, input int t2, input int t3,
                            input int frac);
      t0_s   = CW'(t0);
      t1_s   = CW'(t1);
      t2_s   = CW'(t2);
      t3_s   = CW'(t3);
      frac_s = FB'(frac);
   endtask

   // Accepts one set at the next free slot, leaving the bench at the negedge
   // right after the accepting edge. Returns 0 if in_ready never came.
   task automatic accept_set(input int t0, input int t1, input int t2, input int t3,
                             input int frac, input string tag, output bit ok);
      int waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      ok = in_ready;
      if (!ok) begin
         check({tag, " in_ready timeout"}, 0, 1);
         return;
      end
      drive_set(t0, t1, t2, t3, frac);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      // Scramble inputs so only the accepting edge can have captured them.
      drive_set($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095),
                $urandom_range(0, 4095), $urandom_range(0, 255));
   endtask

   task automatic run_txn(input int t0, input int t1, input int t2, input int t3,
                          input int frac, input int exp, input int hold, input string tag);
      bit ok;
      int lat = 0;
      accept_set(t0, t1, t2, t3, frac, tag, ok);
      if (!ok) return;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, lat, 3);
      check({tag, " pixel"}, int'(out_pixel), exp);
      $display("txn %s: t0=%0d t1=%0d t2=%0d t3=%0d frac=%0d pixel=%0d expected=%0d latency=%0d",
               tag, t0, t1, t2, t3, frac, out_pixel, exp, lat);
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      bit ok;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      drive_set(0, 0, 0, 0, 0);

      vecs[0] = '{t0: 100,  t1: 5,    t2: -3,   t3: 7,    frac: 0,   exp: 100};
      vecs[1] = '{t0: 50,   t1: 0,    t2: 0,    t3: 0,    frac: 128, exp: 50};
      vecs[2] = '{t0: 64,   t1: 64,   t2: 0,    t3: 0,    frac: 128, exp: 96};
      vecs[3] = '{t0: 255,  t1: 200,  t2: 0,    t3: 0,    frac: 255, exp: 255};
      vecs[4] = '{t0: 0,    t1: -100, t2: 0,    t3: 0,    frac: 128, exp: 0};
      vecs[5] = '{t0: 10,   t1: 0,    t2: 0,    t3: -1,   frac: 255, exp: 9};
      vecs[6] = '{t0: 0,    t1: 0,    t2: 0,    t3: 100,  frac: 128, exp: 12};
      vecs[7] = '{t0: 200,  t1: -50,  t2: 30,   t3: -20,  frac: 192, exp: 170};
      vecs[8] = '{t0: 2047, t1: 2047, t2: 2047, t3: 2047, frac: 255, exp: 255};

      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset in_ready", int'(in_ready), 1);
      check("reset out_valid", int'(out_valid), 0);
      check("reset out_pixel", int'(out_pixel), 0);

      for (int i = 0; i < 9; i++) begin
         run_txn(vecs[i].t0, vecs[i].t1, vecs[i].t2, vecs[i].t3, vecs[i].frac,
                 vecs[i].exp, i % 3, $sformatf("vec%0d", i));
      end

      // Backpressure: result must hold and a new set must be refused while DONE.
      accept_set(200, -50, 30, -20, 192, "bp", ok);
      if (ok) begin
         int lat = 0;
         while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         check("bp latency", lat, 3);
         drive_set(5, 0, 0, 0, 0);
         in_valid = 1'b1;
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp pixel hold", int'(out_pixel), 170);
            check("bp in_ready low", int'(in_ready), 0);
            check("bp out_valid high", int'(out_valid), 1);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         check("bp out_valid drop", int'(out_valid), 0);
         check("bp in_ready rise", int'(in_ready), 1);
         @(negedge clk);
         check("bp no stray accept", int'(in_ready), 1);
         check("bp pixel after", int'(out_pixel), 170);
         $display("txn backpressure: pixel=%0d expected=170", out_pixel);
      end

      // Reset on the cycle after acceptance discards the in-flight result.
      accept_set(0, 0, 0, 100, 128, "rst", ok);
      if (ok) begin
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         check("rst in_ready", int'(in_ready), 1);
         check("rst out_valid", int'(out_valid), 0);
         check("rst out_pixel", int'(out_pixel), 0);
         repeat (4) @(negedge clk);
         check("rst no late result", int'(out_valid), 0);
         $display("txn mid-step reset: in_ready=%0d out_valid=%0d pixel=%0d",
                  in_ready, out_valid, out_pixel);
      end
      run_txn(100, 5, -3, 7, 0, 100, 0, "post_rst");

      for (int n = 0; n < 1000; n++) begin
         int a0, a1, a2, a3, f;
         a0 = int'($urandom_range(0, 2047));
         a1 = int'($urandom_range(0, 4095)) - 2048;
         a2 = int'($urandom_range(0, 4095)) - 2048;
         a3 = int'($urandom_range(0, 4095)) - 2048;
         f  = (n % 4 == 0) ? 255 : int'($urandom_range(0, 255));
         run_txn(a0, a1, a2, a3, f, ref_pixel(a0, a1, a2, a3, f),
                 int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
